soma_seq_nbit: RTL and testbench

SOMA_SEQ_NBIT -- requirements
Module: soma_seq_nbit

---
 rtl/soma_seq_nbit.sv | 160 ++++++++++++++++
 tb/tb_soma_seq_nbit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/soma_seq_nbit.sv
// soma_seq_nbit: multi-cycle adder/subtractor that processes CHUNK bits per clock.
//
// An operation is requested with start while idle. The operands are latched and
// then summed one CHUNK-wide slice per cycle, LSB slice first. Completion takes
// K = WIDTH/CHUNK cycles. Completion raises done for one cycle and updates result,
// c_out and overflow, which then hold until the next completion.
//
// Build option:
//   SOMA_SEQ_SUB_EN  defined   : sub = 1 selects A - B, computed as A + ~B + 1.
//   SOMA_SEQ_SUB_EN  undefined : sub is ignored, and every operation is A + B.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request; a, b and sub are sampled when high in IDLE
//   a, b      WIDTH-bit operands
//   sub       0 = A + B, 1 = A - B (subtract build only)
//   busy      high while an operation is in progress
//   done      one-cycle pulse when a new result is available
//   result    sum or difference, modulo 2^WIDTH
//   c_out     carry out of the MSB (for subtract, 1 = no borrow)
//   overflow  signed overflow of the last completed operation

module soma_seq_nbit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow
);

    localparam int unsigned K    = WIDTH / CHUNK;
    localparam int unsigned IdxW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(K - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] partial_q, partial_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             c_out_q, c_out_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;

    logic             sub_eff;
    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             msb_cin;
    logic [WIDTH+CHUNK-1:0] partial_cat;

`ifdef SOMA_SEQ_SUB_EN
    assign sub_eff = sub;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign sub_eff    = 1'b0;
`endif

    // Operands are shifted right every cycle, so the active slice is always the
    // low CHUNK bits.
    assign a_chunk   = a_q[CHUNK-1:0];
    assign b_chunk   = b_q[CHUNK-1:0];
    assign chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

    // The carry into the MSB is recovered from the sum bit of the MSB position.
    // This value is meaningful only on the last slice.
    assign msb_cin = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];

    // New slices enter at the top of partial. After K cycles, slice 0 has reached
    // the bottom. The concatenation keeps this form legal when K = 1.
    assign partial_cat = {chunk_sum[CHUNK-1:0], partial_q};

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        carry_d    = carry_q;
        idx_d      = idx_q;
        partial_d  = partial_q;
        result_d   = result_q;
        c_out_d    = c_out_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StRun;
                    a_d       = a;
                    b_d       = sub_eff ? ~b : b;
                    carry_d   = sub_eff;
                    idx_d     = '0;
                    partial_d = '0;
                end
            end
            StRun: begin
                a_d       = a_q >> CHUNK;
                b_d       = b_q >> CHUNK;
                carry_d   = chunk_sum[CHUNK];
                partial_d = partial_cat[WIDTH+CHUNK-1:CHUNK];
                idx_d     = idx_q + IdxW'(1);
                if (idx_q == LastIdx) begin
                    state_d    = StIdle;
                    idx_d      = '0;
                    done_d     = 1'b1;
                    result_d   = partial_cat[WIDTH+CHUNK-1:CHUNK];
                    c_out_d    = chunk_sum[CHUNK];
                    overflow_d = msb_cin ^ chunk_sum[CHUNK];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            partial_q  <= '0;
            result_q   <= '0;
            c_out_q    <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            carry_q    <= carry_d;
            idx_q      <= idx_d;
            partial_q  <= partial_d;
            result_q   <= result_d;
            c_out_q    <= c_out_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q == StRun);
    assign done     = done_q;
    assign result   = result_q;
    assign c_out    = c_out_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_soma_seq_nbit.sv
// Directed bench for soma_seq_nbit with WIDTH = 16 and CHUNK = 4.
//
// A table of vectors checks result, carry, overflow, latency and busy length.
// Hand sequences then cover these cases:
//   - start while busy
//   - start held during the done cycle
//   - reset during an operation

module tb_soma_seq_nbit;

    localparam int W = 16;
    localparam int C = 4;
    localparam int K = W / C;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         c_out;
    logic         overflow;

    int passed = 0;
    int total  = 0;

    soma_seq_nbit #(.WIDTH(W), .CHUNK(C)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .c_out    (c_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vsub;
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Call this just after a start edge. n0 is the number of negedges already
    // consumed since that edge. The task returns on the negedge where done is
    // seen. lat counts edges from start to done, or is -1 on timeout.
    task automatic wait_done(input int n0, output int lat, output int nbusy);
        lat   = -1;
        nbusy = 0;
        for (int n = n0 + 1; n <= 20; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = n - 1;
                break;
            end
            if (busy) nbusy++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                          output int lat, output int nbusy);
        @(negedge clk);
        a = ta; b = tb; sub = ts; start = 1'b1;
        @(posedge clk);
        wait_done(0, lat, nbusy);
    endtask

    initial begin
        int lat, nbusy, ndone;
        logic [W-1:0] held;

        vecs[0] = '{va: 16'h0004, vb: 16'h0002, vsub: 1'b0, res: 16'h0006, co: 1'b0, ov: 1'b0};
        vecs[1] = '{va: 16'hFFFF, vb: 16'h0001, vsub: 1'b0, res: 16'h0000, co: 1'b1, ov: 1'b0};
        vecs[2] = '{va: 16'h7FFF, vb: 16'h0001, vsub: 1'b0, res: 16'h8000, co: 1'b0, ov: 1'b1};
`ifdef SOMA_SEQ_SUB_EN
        vecs[3] = '{va: 16'h000A, vb: 16'h0006, vsub: 1'b1, res: 16'h0004, co: 1'b1, ov: 1'b0};
`else
        vecs[3] = '{va: 16'h000A, vb: 16'h0006, vsub: 1'b1, res: 16'h0010, co: 1'b0, ov: 1'b0};
`endif
        vecs[4] = '{va: 16'h8000, vb: 16'h8000, vsub: 1'b0, res: 16'h0000, co: 1'b1, ov: 1'b1};
        vecs[5] = '{va: 16'h1234, vb: 16'h4321, vsub: 1'b0, res: 16'h5555, co: 1'b0, ov: 1'b0};

        // Reset state.
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vsub, lat, nbusy);
            check($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].res));
            check($sformatf("v%0d_c_out", i), 32'(c_out), 32'(vecs[i].co));
            check($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].ov));
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(K));
            check($sformatf("v%0d_busy_cycles", i), 32'(nbusy), 32'(K));
            check($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
            check($sformatf("v%0d_result_hold", i), 32'(result), 32'(vecs[i].res));
        end

        // Start while busy: the second request is ignored.
        @(negedge clk);
        a = 16'h0001; b = 16'h0009; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'h1111; b = 16'h1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'hFFFF; b = 16'hFFFF;
        wait_done(3, lat, nbusy);
        check("busy_ign_latency", 32'(lat), 32'(K));
        check("busy_ign_result", 32'(result), 32'h000A);

        // Start held in the done cycle is accepted.
        a = 16'h000A; b = 16'h0006; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_no_partial", 32'(result), 32'h000A);
        wait_done(1, lat, nbusy);
        check("b2b_latency", 32'(lat), 32'(K));
        check("b2b_result", 32'(result), 32'h0010);

        // Reset during an operation.
        run_op(16'h8001, 16'h8000, 1'b0, lat, nbusy);
        check("pre_rst_result", 32'(result), 32'h0001);
        check("pre_rst_c_out", 32'(c_out), 32'd1);
        check("pre_rst_overflow", 32'(overflow), 32'd1);
        @(negedge clk);
        a = 16'h1234; b = 16'h0001; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_c_out", 32'(c_out), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("mid_rst_no_done", 32'(ndone), 32'd0);
        held = result;
        check("mid_rst_result_hold", 32'(held), 32'd0);
        run_op(16'h0003, 16'h0004, 1'b0, lat, nbusy);
        check("post_rst_result", 32'(result), 32'h0007);
        check("post_rst_latency", 32'(lat), 32'(K));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
